// File: rtl/sopc_data_bus_pkg.sv
// Shared definitions for the data-side interconnect: FSM encoding, defaults
// and the slave index map used by the SoC.
package sopc_data_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bus_state_t;

  localparam int DEF_TIMEOUT = 15;

  localparam int SLV_RAM   = 0;
  localparam int SLV_UART  = 1;
  localparam int SLV_GPIO  = 2;
  localparam int SLV_TIMER = 3;

  // Width needed to hold a BUSY-cycle count up to and including the timeout.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sopc_data_bus_if.sv
// Slave-side bus of the data interconnect: one-hot request, shared
// latched command, per-slave read data and acknowledge.
interface sopc_data_bus_if #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [NUM_SLV-1:0]        s_cyc;
  logic                      s_we;
  logic [ADDR_W-1:0]         s_addr;
  logic [DATA_W-1:0]         s_wdata;
  logic [DATA_W/8-1:0]       s_sel;
  logic [NUM_SLV*DATA_W-1:0] s_rdata;
  logic [NUM_SLV-1:0]        s_ack;

  modport master (
    output s_cyc, s_we, s_addr, s_wdata, s_sel,
    input  s_rdata, s_ack
  );

  modport slave (
    input  s_cyc, s_we, s_addr, s_wdata, s_sel,
    output s_rdata, s_ack
  );

endinterface

// File: rtl/sopc_addr_decode.sv
// Combinational address decode: top address bits select a slave; indices
// beyond the populated slave count are flagged invalid.
module sopc_addr_decode #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int SEL_W   = $clog2(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] onehot,
  output logic [SEL_W-1:0]   idx,
  output logic               invalid
);

  logic unused_low;
  assign unused_low = ^addr[ADDR_W-SEL_W-1:0];

  assign idx     = addr[ADDR_W-1 -: SEL_W];
  assign invalid = ({1'b0, idx} >= (SEL_W+1)'(NUM_SLV));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      onehot[i] = (idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/sopc_data_bus.sv
// Data-side interconnect between the CPU data port and NUM_SLV slaves with
// request/ack handshake, pipeline stall and timeout-to-bus-error.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for cpu_ce; command latched and decoded on request
//   BUSY    | one-hot s_cyc held until ack or timeout
//   DONE    | result (rdata / bus_err) presented for one cycle, stall released
module sopc_data_bus
  import sopc_data_bus_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_ce,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_sel,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                stallreq,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   err_addr,
  sopc_data_bus_if.master     bus
);

  localparam int SEL_W = $clog2(NUM_SLV);
  localparam int CNT_W = cnt_width(TIMEOUT);

  bus_state_t         state, state_nxt;
  logic [NUM_SLV-1:0] dec_onehot;
  logic [SEL_W-1:0]   dec_idx;
  logic               dec_invalid;
  logic [SEL_W-1:0]   cur_idx;
  logic [CNT_W-1:0]   cnt;
  logic               start, fin_ok, fin_err;
  logic               ack_hit, cnt_hit;
  logic [DATA_W-1:0]  rdata_sel;

  sopc_addr_decode #(
    .NUM_SLV (NUM_SLV),
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W)
  ) u_addr_decode (
    .addr    (cpu_addr),
    .onehot  (dec_onehot),
    .idx     (dec_idx),
    .invalid (dec_invalid)
  );

  // s_cyc is one-hot, so masking filters out acks from unselected slaves.
  assign ack_hit = |(bus.s_cyc & bus.s_ack);
  assign cnt_hit = (cnt == CNT_W'(TIMEOUT));

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (cur_idx == SEL_W'(i)) begin
        rdata_sel = bus.s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Reset gates the request so the pipeline is never stalled while held in reset.
  assign stallreq = rst & cpu_ce & (state != ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_ce) begin
          start = 1'b1;
          if (dec_invalid) begin
            fin_err   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // An ack arriving on the timeout cycle still completes normally.
        if (ack_hit) begin
          fin_ok    = 1'b1;
          state_nxt = ST_DONE;
        end else if (cnt_hit) begin
          fin_err   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.s_cyc   <= '0;
      bus.s_we    <= 1'b0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.s_sel   <= '0;
      cur_idx     <= '0;
      cnt         <= '0;
      cpu_rdata   <= '0;
      bus_err     <= 1'b0;
      err_addr    <= '0;
    end else begin
      bus_err <= 1'b0;
      if (start) begin
        bus.s_we    <= cpu_we;
        bus.s_addr  <= cpu_addr;
        bus.s_wdata <= cpu_wdata;
        bus.s_sel   <= cpu_sel;
        cur_idx     <= dec_idx;
        cnt         <= '0;
        bus.s_cyc   <= dec_invalid ? '0 : dec_onehot;
      end else if (state == ST_BUSY && !fin_ok && !fin_err) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (fin_ok || fin_err) begin
        bus.s_cyc <= '0;
      end
      if (fin_ok) begin
        cpu_rdata <= bus.s_we ? '0 : rdata_sel;
      end
      if (fin_err) begin
        bus_err   <= 1'b1;
        cpu_rdata <= '0;
        err_addr  <= start ? cpu_addr : bus.s_addr;
      end
    end
  end

endmodule

// File: tb/tb_sopc_data_bus.sv
// Directed bench for sopc_data_bus: a vector table of single transactions
// plus hand sequences for back-to-back, flush, reset and decode errors.
module tb_sopc_data_bus;

  localparam int NS  = 4;
  localparam int TO  = 15;
  localparam int NS3 = 3;
  localparam int TO3 = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // main instance: 4 slaves, timeout 15
  logic        cpu_ce, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, err_addr;
  logic [3:0]  cpu_sel;
  logic        stallreq, bus_err;

  sopc_data_bus_if #(.NUM_SLV(NS), .ADDR_W(32), .DATA_W(32)) bus ();

  sopc_data_bus #(.NUM_SLV(NS), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce    (cpu_ce),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_sel   (cpu_sel),
    .cpu_rdata (cpu_rdata),
    .stallreq  (stallreq),
    .bus_err   (bus_err),
    .err_addr  (err_addr),
    .bus       (bus.master)
  );

  // slave model: slave i acks once its s_cyc has been high dly[i] earlier cycles
  logic [3:0] ack_en, stray;
  int         dly[NS];
  int         busy_cnt[NS];

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) busy_cnt[i] <= bus.s_cyc[i] ? busy_cnt[i] + 1 : 0;
  end

  always_comb begin
    bus.s_ack = stray;
    for (int i = 0; i < NS; i++) begin
      if (bus.s_cyc[i] && ack_en[i] && busy_cnt[i] >= dly[i]) bus.s_ack[i] = 1'b1;
    end
  end

  assign bus.s_rdata = {32'hCAFE_0003, 32'h0BAD_F00D, 32'hA5A5_0001, 32'hDEAD_BEEF};

  // second instance: 3 slaves, timeout 4, combinational-ack slaves
  logic        ce3, stall3, err3;
  logic [31:0] addr3, rdata3, ea3;
  logic [2:0]  ack3_en;

  sopc_data_bus_if #(.NUM_SLV(NS3), .ADDR_W(32), .DATA_W(32)) bus3 ();

  sopc_data_bus #(.NUM_SLV(NS3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce    (ce3),
    .cpu_we    (1'b0),
    .cpu_addr  (addr3),
    .cpu_wdata (32'h0),
    .cpu_sel   (4'hF),
    .cpu_rdata (rdata3),
    .stallreq  (stall3),
    .bus_err   (err3),
    .err_addr  (ea3),
    .bus       (bus3.master)
  );

  assign bus3.s_ack   = bus3.s_cyc & ack3_en;
  assign bus3.s_rdata = {32'hC3C3_0002, 32'hB2B2_0001, 32'hA1A1_0000};

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          dly;
    logic [3:0]  ack_en;
    logic [3:0]  stray;
    int          exp_done;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cyc_hi;
    logic [3:0]  exp_onehot;
    logic [31:0] exp_err_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry and exit at posedge+1. Cycle 0 is the IDLE cycle presenting the request.
  task automatic run_txn(input vec_t v, input int id);
    int          tgt, done_cyc, cyc_hi;
    logic        ok, g_err;
    logic [31:0] g_rd, g_ea;
    tgt      = int'(v.addr[31:30]);
    dly[tgt] = v.dly;
    ack_en   = v.ack_en;
    stray    = v.stray;
    cpu_ce   = 1'b1;
    cpu_we   = v.we;
    cpu_addr = v.addr;
    cpu_wdata = v.wdata;
    cpu_sel  = v.sel;
    done_cyc = -1;
    cyc_hi   = 0;
    ok       = 1'b1;
    g_err    = 1'b0;
    g_rd     = '0;
    g_ea     = '0;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (bus.s_cyc != 4'b0) begin
        cyc_hi++;
        if (bus.s_cyc != v.exp_onehot || bus.s_sel != v.sel || bus.s_addr != v.addr ||
            bus.s_we != v.we || bus.s_wdata != v.wdata) ok = 1'b0;
      end
      if (!stallreq) begin
        done_cyc = c;
        g_err    = bus_err;
        g_rd     = cpu_rdata;
        g_ea     = err_addr;
      end
      tick();
    end
    cpu_ce = 1'b0;
    stray  = 4'b0;
    @(negedge clk);
    chk($sformatf("v%0d_err_pulse_end", id), {bus_err, bus.s_cyc}, 5'b0);
    tick();
    chk($sformatf("v%0d_done_cycle", id), done_cyc, v.exp_done);
    chk($sformatf("v%0d_bus_err", id), g_err, v.exp_err);
    chk($sformatf("v%0d_cpu_rdata", id), g_rd, v.exp_rdata);
    chk($sformatf("v%0d_s_cyc_cycles", id), cyc_hi, v.exp_cyc_hi);
    chk($sformatf("v%0d_s_bus_fields", id), ok, 1'b1);
    chk($sformatf("v%0d_err_addr", id), g_ea, v.exp_err_addr);
  endtask

  task automatic run3(input string nm, input logic [31:0] a, input logic [2:0] en,
                      input int e_done, input logic e_err, input logic [31:0] e_rd,
                      input int e_hi, input logic [31:0] e_ea);
    int          d, hi;
    logic        g_err;
    logic [31:0] g_rd, g_ea;
    ack3_en = en;
    ce3     = 1'b1;
    addr3   = a;
    d       = -1;
    hi      = 0;
    g_err   = 1'b0;
    g_rd    = '0;
    g_ea    = '0;
    for (int c = 0; c < 30 && d < 0; c++) begin
      @(negedge clk);
      if (bus3.s_cyc != 3'b0) hi++;
      if (!stall3) begin
        d     = c;
        g_err = err3;
        g_rd  = rdata3;
        g_ea  = ea3;
      end
      tick();
    end
    ce3 = 1'b0;
    @(negedge clk);
    chk({nm, "_err_pulse_end"}, err3, 1'b0);
    tick();
    chk({nm, "_done_cycle"}, d, e_done);
    chk({nm, "_bus_err"}, g_err, e_err);
    chk({nm, "_cpu_rdata"}, g_rd, e_rd);
    chk({nm, "_s_cyc_cycles"}, hi, e_hi);
    chk({nm, "_err_addr"}, g_ea, e_ea);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [4:0]  bb_stall, bb_cyc;
    logic [3:0]  fl_cyc[5];

    //          we    addr          wdata         sel      dly ack_en   stray    done err   rdata         hi  onehot   err_addr
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF,    0,  4'hF,    4'h0,    2,   1'b0, 32'hDEAD_BEEF, 1,  4'b0001, 32'h0};
    vecs[1] = '{1'b1, 32'h4000_0004, 32'h1234_5678, 4'b0011, 3,  4'hF,    4'h0,    5,   1'b0, 32'h0,         4,  4'b0010, 32'h0};
    vecs[2] = '{1'b0, 32'h8000_0008, 32'h0,        4'hF,    0,  4'b1011, 4'h0,    17,  1'b1, 32'h0,         16, 4'b0100, 32'h8000_0008};
    vecs[3] = '{1'b0, 32'hC000_00FC, 32'h0,        4'hF,    15, 4'hF,    4'h0,    17,  1'b0, 32'hCAFE_0003, 16, 4'b1000, 32'h8000_0008};
    vecs[4] = '{1'b0, 32'h4000_0000, 32'h0,        4'hF,    1,  4'hF,    4'h0,    3,   1'b0, 32'hA5A5_0001, 2,  4'b0010, 32'h8000_0008};
    vecs[5] = '{1'b0, 32'h0000_0020, 32'h0,        4'hF,    2,  4'hF,    4'b1000, 4,   1'b0, 32'hDEAD_BEEF, 3,  4'b0001, 32'h8000_0008};
    vecs[6] = '{1'b0, 32'h8000_0010, 32'h0,        4'hF,    14, 4'hF,    4'h0,    16,  1'b0, 32'h0BAD_F00D, 15, 4'b0100, 32'h8000_0008};
    vecs[7] = '{1'b1, 32'hC000_0000, 32'hAABB_CCDD, 4'b1000, 0,  4'hF,    4'h0,    2,   1'b0, 32'h0,         1,  4'b1000, 32'h8000_0008};

    for (int i = 0; i < NS; i++) dly[i] = 0;
    ack_en    = 4'hF;
    stray     = 4'h0;
    ack3_en   = 3'b111;
    cpu_ce    = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0000_0010;
    cpu_wdata = 32'h0;
    cpu_sel   = 4'hF;
    ce3       = 1'b1;
    addr3     = 32'h0;

    // reset with a pending request: nothing may leak out
    repeat (2) tick();
    @(negedge clk);
    chk("reset_stallreq", {stallreq, stall3}, 2'b00);
    chk("reset_s_cyc", {bus.s_cyc, bus3.s_cyc}, 7'b0);
    chk("reset_outputs", {bus_err, cpu_rdata, err_addr}, 65'b0);
    tick();
    cpu_ce = 1'b0;
    ce3    = 1'b0;
    rst    = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // back-to-back: request held through DONE is re-accepted in the next IDLE
    bb_stall = 5'b11011;
    bb_cyc   = 5'b10010;
    dly[0]   = 0;
    ack_en   = 4'hF;
    cpu_ce   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0004;
    cpu_sel  = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_c%0d_stallreq", c), stallreq, bb_stall[c]);
      chk($sformatf("b2b_c%0d_s_cyc", c), bus.s_cyc, bb_cyc[c] ? 4'b0001 : 4'b0000);
      tick();
    end
    cpu_ce = 1'b0;
    @(negedge clk);
    chk("b2b_second_rdata", cpu_rdata, 32'hDEAD_BEEF);
    tick();

    // flush: cpu_ce drops mid-BUSY, the slave access still runs to its ack
    fl_cyc   = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    dly[1]   = 3;
    cpu_ce   = 1'b1;
    cpu_addr = 32'h4000_0008;
    tick();
    tick();
    cpu_ce = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("flush_c%0d_s_cyc", c + 2), {stallreq, bus.s_cyc}, {1'b0, fl_cyc[c]});
      tick();
    end
    v = vecs[4];
    v.exp_err_addr = 32'h8000_0008;
    run_txn(v, 40);

    // reset mid-BUSY on a silent slave
    ack_en   = 4'b1011;
    cpu_ce   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h8000_0000;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mid_pre_s_cyc", bus.s_cyc, 4'b0100);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_s_cyc", bus.s_cyc, 4'b0000);
    chk("rst_mid_stallreq", stallreq, 1'b0);
    chk("rst_mid_bus_err", bus_err, 1'b0);
    chk("rst_mid_err_addr", err_addr, 32'h0);
    cpu_ce = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    run_txn(vecs[0], 50);

    // 3-slave instance: decode error, short timeout, normal read
    run3("dec_err", 32'hC000_0000, 3'b111, 1, 1'b1, 32'h0, 0, 32'hC000_0000);
    run3("to4", 32'h8000_0004, 3'b000, 2 + TO3, 1'b1, 32'h0, TO3 + 1, 32'h8000_0004);
    run3("rd3", 32'h4000_0000, 3'b111, 2, 1'b0, 32'hB2B2_0001, 1, 32'h8000_0004);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sopc_data_bus.md
# sopc_data_bus

Parametrised data-side interconnect between the openMIPS data-memory port and NUM_SLV slave channels (data RAM, peripherals). It replaces the direct CPU-to-RAM wiring in the SoC top, adding address decode, multi-cycle slave support via a request/acknowledge handshake, CPU stall generation, and a timeout that converts a silent slave into a bus error. It sits between `openmips` and the data-side slaves; instruction fetch is not routed through it.

## Interface
- NUM_SLV, 4: slave channel count, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width, multiple of 8.
- TIMEOUT, 15: max BUSY cycles before error, 1..255.
- SEL_W, clog2(NUM_SLV): derived; slave index = addr[ADDR_W-1 -: SEL_W].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- cpu_ce  in  1  data request valid, held by CPU while stallreq=1.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_sel  in  DATA_W/8  byte enables.
- cpu_rdata  out  DATA_W  read data, valid in DONE.
- stallreq  out  1  stall request to pipeline control.
- bus_err  out  1  one-cycle error flag, DONE cycle only.
- err_addr  out  ADDR_W  address of last failed access.
- s_cyc  out  NUM_SLV  one-hot slave request.
- s_we  out  1  shared write enable.
- s_addr  out  ADDR_W  shared latched address.
- s_wdata  out  DATA_W  shared latched write data.
- s_sel  out  DATA_W/8  shared latched byte enables.
- s_rdata  in  NUM_SLV*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W].
- s_ack  in  NUM_SLV  slave completion, may be combinational from s_cyc.

## Operation
- FSM states IDLE, BUSY, DONE; reset → IDLE; all outputs and registers 0.
- IDLE, cpu_ce=1: latch we/addr/wdata/sel into s_*; decode index. Index < NUM_SLV → BUSY, s_cyc[index]=1, counter=0. Index ≥ NUM_SLV → DONE with error, no s_cyc.
- BUSY: s_cyc held one-hot, s_* stable. s_ack[index]=1 → DONE; on read capture s_rdata slice into cpu_rdata, on write cpu_rdata=0; drop s_cyc. Acks from other slaves ignored. Else counter+1; counter reaching TIMEOUT with no ack → DONE with error, cpu_rdata=0, drop s_cyc.
- DONE: bus_err=1 if error; err_addr updated on error only (holds otherwise). Next state always IDLE.
- stallreq = cpu_ce & (state != DONE), combinational.
- cpu_ce dropping mid-BUSY (flush): transaction still completes or times out; result discarded; stallreq follows cpu_ce.
- Ack and timeout in the same cycle: ack wins, no error.

## Timing
- Best case (combinational ack): request seen cycle 0 (IDLE), s_cyc cycle 1, DONE cycle 2; stallreq high cycles 0–1, low cycle 2; pipeline advances at end of cycle 2.
- Slave with k-cycle ack delay: DONE at cycle 2+k.
- Timeout: DONE at cycle 2+TIMEOUT; s_cyc high exactly TIMEOUT+1 cycles.
- Decode error: DONE at cycle 1.
- Back-to-back: new request accepted in the IDLE cycle following DONE; one idle bubble minimum.
- rst asserted any time: immediate return to IDLE, s_cyc=0, stallreq=0 (cpu_ce gated by reset), bus_err=0.

## Structure
- Shared defines (`define.v`): state encodings, default TIMEOUT, slave index map names (RAM=0, UART=1, GPIO=2, TIMER=3).
- Sub-module `sopc_addr_decode`: combinational addr → one-hot select plus invalid flag; reused by future instruction-side interconnect.
- Counter width clog2(TIMEOUT+1).

## Test plan
- Read RAM (slave 0, combinational ack), addr 0x0000_0010, s_rdata0=0xDEAD_BEEF → stallreq 2 cycles, cpu_rdata=0xDEAD_BEEF in DONE, bus_err=0.
- Write slave 1, addr 0x4000_0004, wdata 0x1234_5678, sel 4'b0011, ack after 3 cycles → s_cyc=4'b0010 for 4 cycles, s_sel=4'b0011, DONE cycle 5, cpu_rdata=0.
- NUM_SLV=3, addr 0xC000_0000 → no s_cyc, bus_err pulse cycle 1, err_addr=0xC000_0000.
- Slave 2 never acks, TIMEOUT=15 → s_cyc high 16 cycles, bus_err in cycle 17, cpu_rdata=0.
- Ack in same cycle counter hits TIMEOUT → normal completion, bus_err=0; stray ack from slave 3 during slave 0 transaction ignored.
- rst low mid-BUSY → s_cyc, stallreq, bus_err all 0 immediately; after release, next request completes normally.
